// File: rtl/axi_pkg.sv
// Shared types for the AXI4-Lite write responder: response codes and FSM states.
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    RESP
  } wr_state_t;

endpackage

// File: rtl/wr_capture_reg.sv
// Single-entry valid/ready capture register. READY is registered and is only
// offered while the parent enables capture and the entry is empty.
module wr_capture_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear,
  output logic             ready,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_reg;
  logic             full_next;
  logic             ready_reg;
  logic [WIDTH-1:0] data_reg;
  logic             load;

  assign load = valid & ready_reg;

  always_comb begin
    full_next = full_reg;
    if (clear) begin
      full_next = 1'b0;
    end else if (load) begin
      full_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg  <= 1'b0;
      ready_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      full_reg  <= full_next;
      // Looking at the next fill state keeps READY from re-opening on the load edge.
      ready_reg <= enable & ~full_next;
      if (load) begin
        data_reg <= data_in;
      end else if (clear) begin
        data_reg <= '0;
      end
    end
  end

  assign ready = ready_reg;
  assign full  = full_reg;
  assign data  = data_reg;

endmodule

// File: rtl/axi_lite_wr_slave.sv
// AXI4-Lite write responder: captures AW and W in any order, commits to a simple
// memory port and returns B. Define AXI_WSTRB_EN to add WSTRB/mem_wstrb.
module axi_lite_wr_slave
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
`ifdef AXI_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
`endif
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [1:0]              BRESP,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
`ifdef AXI_WSTRB_EN
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
`endif
  input  logic                    mem_busy
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
`ifdef AXI_WSTRB_EN
  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int W_CAP_WIDTH = DATA_WIDTH + STRB_WIDTH;
`else
  localparam int W_CAP_WIDTH = DATA_WIDTH;
`endif

  wr_state_t state_reg;
  wr_state_t state_next;
  resp_t     bresp_reg;
  resp_t     bresp_next;

  logic                   aw_ready;
  logic                   aw_full;
  logic [ADDR_WIDTH-1:0]  aw_data;
  logic                   w_ready;
  logic                   w_full;
  logic [W_CAP_WIDTH-1:0] w_in;
  logic [W_CAP_WIDTH-1:0] w_data;
  logic [DATA_WIDTH-1:0]  wdata_cap;
  logic                   aw_hs;
  logic                   w_hs;
  logic                   capture_en;
  logic                   txn_done;
  logic                   in_range;
  logic                   strb_any;

`ifdef AXI_WSTRB_EN
  logic [STRB_WIDTH-1:0] wstrb_cap;
  assign w_in      = {WSTRB, WDATA};
  assign wdata_cap = w_data[DATA_WIDTH-1:0];
  assign wstrb_cap = w_data[W_CAP_WIDTH-1:DATA_WIDTH];
  assign strb_any  = |wstrb_cap;
  assign mem_wstrb = (state_reg == WRITE) ? wstrb_cap : '0;
`else
  assign w_in      = WDATA;
  assign wdata_cap = w_data;
  assign strb_any  = 1'b1;
`endif

  assign aw_hs      = AWVALID & aw_ready;
  assign w_hs       = WVALID & w_ready;
  assign capture_en = (state_next == IDLE) || (state_next == COLLECT);
  assign in_range   = ({1'b0, aw_data} < DEPTH_LIMIT);

  wr_capture_reg #(.WIDTH(ADDR_WIDTH)) u_aw_cap (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .enable  (capture_en),
    .valid   (AWVALID),
    .data_in (AWADDR),
    .clear   (txn_done),
    .ready   (aw_ready),
    .full    (aw_full),
    .data    (aw_data)
  );

  wr_capture_reg #(.WIDTH(W_CAP_WIDTH)) u_w_cap (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .enable  (capture_en),
    .valid   (WVALID),
    .data_in (w_in),
    .clear   (txn_done),
    .ready   (w_ready),
    .full    (w_full),
    .data    (w_data)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg <= IDLE;
      bresp_reg <= OKAY;
    end else begin
      state_reg <= state_next;
      bresp_reg <= bresp_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bresp_next = bresp_reg;
    mem_we     = 1'b0;
    txn_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (aw_hs && w_hs) begin
          state_next = WRITE;
        end else if (aw_hs || w_hs) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if ((aw_full || aw_hs) && (w_full || w_hs)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        // Out-of-range and empty-strobe writes never touch memory, so stalls don't apply.
        if (!in_range) begin
          state_next = RESP;
          bresp_next = SLVERR;
        end else if (!strb_any) begin
          state_next = RESP;
          bresp_next = OKAY;
        end else if (!mem_busy) begin
          mem_we     = 1'b1;
          state_next = RESP;
          bresp_next = OKAY;
        end
      end
      RESP: begin
        if (BREADY) begin
          txn_done   = 1'b1;
          state_next = IDLE;
          bresp_next = OKAY;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign AWREADY   = aw_ready;
  assign WREADY    = w_ready;
  assign BVALID    = (state_reg == RESP);
  assign BRESP     = bresp_reg;
  assign mem_addr  = (state_reg == WRITE) ? aw_data : '0;
  assign mem_wdata = (state_reg == WRITE) ? wdata_cap : '0;

endmodule

// File: tb/tb_axi_lite_wr_slave.sv
// Self-checking bench for axi_lite_wr_slave: directed plan items plus random
// transactions checked against a transaction-level memory/response model.
module tb_axi_lite_wr_slave;

  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;
  logic       AWVALID = 1'b0;
  logic       AWREADY;
  logic [7:0] AWADDR = '0;
  logic       WVALID = 1'b0;
  logic       WREADY;
  logic [7:0] WDATA = '0;
  logic       BVALID;
  logic       BREADY = 1'b0;
  logic [1:0] BRESP;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_busy = 1'b0;
`ifdef AXI_WSTRB_EN
  logic [0:0] WSTRB = 1'b1;
  logic [0:0] mem_wstrb;
`endif

  int checks = 0;
  int failures = 0;
  int txn_count = 0;
  logic [15:0] commit_q[$];
  logic [7:0]  model_mem[16];
  logic [7:0]  seen_mem[16];

  always #5 ACLK = ~ACLK;

  axi_lite_wr_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(16)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .AWVALID   (AWVALID),
    .AWREADY   (AWREADY),
    .AWADDR    (AWADDR),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .WDATA     (WDATA),
`ifdef AXI_WSTRB_EN
    .WSTRB     (WSTRB),
`endif
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .BRESP     (BRESP),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
`ifdef AXI_WSTRB_EN
    .mem_wstrb (mem_wstrb),
`endif
    .mem_busy  (mem_busy)
  );

  // A commit happens on the rising edge following a low phase with mem_we=1 and mem_busy=0.
  always @(negedge ACLK) begin
    if (ARESETn && mem_we && !mem_busy) commit_q.push_back({mem_addr, mem_wdata});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // order: 0 = AW and W together, 1 = W first, 2 = AW first; gap = idle cycles in between.
  task automatic run_txn(input logic [7:0] addr, input logic [7:0] data, input int order,
                         input int gap, input int busy, input int bdelay, input logic strb);
    logic        commit;
    logic [1:0]  exp_resp;
    int          exp_wlen;
    int          wcyc;
    int          busy_left;
    logic [15:0] c;
    commit   = (addr < 8'd16) && strb;
    exp_resp = (addr < 8'd16) ? 2'b00 : 2'b10;
    exp_wlen = commit ? busy + 1 : 1;
    busy_left = busy;

    @(negedge ACLK);
    chk("idle_ready", {AWREADY, WREADY}, 2'b11);
    AWADDR = addr;
    WDATA  = data;
`ifdef AXI_WSTRB_EN
    WSTRB  = strb;
`endif
    if (order == 0) begin
      AWVALID = 1'b1;
      WVALID  = 1'b1;
      mem_busy = (busy_left > 0);
      tick();
      AWVALID = 1'b0;
      WVALID  = 1'b0;
    end else if (order == 1) begin
      WVALID = 1'b1;
      tick();
      WVALID = 1'b0;
      for (int i = 0; i < gap; i++) begin
        @(negedge ACLK);
        chk("wfirst_wready", WREADY, 1'b0);
        chk("wfirst_awready", AWREADY, 1'b1);
      end
      AWVALID = 1'b1;
      mem_busy = (busy_left > 0);
      tick();
      AWVALID = 1'b0;
    end else begin
      AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      for (int i = 0; i < gap; i++) begin
        @(negedge ACLK);
        chk("awfirst_awready", AWREADY, 1'b0);
        chk("awfirst_wready", WREADY, 1'b1);
      end
      WVALID = 1'b1;
      mem_busy = (busy_left > 0);
      tick();
      WVALID = 1'b0;
    end

    wcyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge ACLK);
      if (BVALID) break;
      chk("write_we", mem_we, commit && !mem_busy);
      chk("write_addr", mem_addr, addr);
      chk("write_data", mem_wdata, data);
      chk("write_ready", {AWREADY, WREADY}, 2'b00);
`ifdef AXI_WSTRB_EN
      chk("write_strb", mem_wstrb, strb);
`endif
      wcyc++;
      tick();
      busy_left--;
      mem_busy = (busy_left > 0);
    end
    chk("write_len", wcyc, exp_wlen);
    mem_busy = 1'b0;

    for (int i = 0; i < bdelay; i++) begin
      chk("resp_hold_bvalid", BVALID, 1'b1);
      chk("resp_hold_bresp", BRESP, exp_resp);
      chk("resp_hold_ready", {AWREADY, WREADY}, 2'b00);
      @(negedge ACLK);
    end
    chk("resp_bvalid", BVALID, 1'b1);
    chk("resp_bresp", BRESP, exp_resp);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    @(negedge ACLK);
    chk("post_bvalid", BVALID, 1'b0);
    chk("post_ready", {AWREADY, WREADY}, 2'b11);

    chk("n_commit", commit_q.size(), commit ? 1 : 0);
    if (commit_q.size() > 0) begin
      c = commit_q.pop_front();
      chk("commit_addr", c[15:8], addr);
      chk("commit_data", c[7:0], data);
      if (c[15:8] < 8'd16) seen_mem[c[11:8]] = c[7:0];
    end
    commit_q.delete();
    if (commit) model_mem[addr[3:0]] = data;
    txn_count++;
    $display("txn %0d addr=%02h data=%02h order=%0d gap=%0d busy=%0d bdelay=%0d strb=%0b exp_resp=%0b",
             txn_count, addr, data, order, gap, busy, bdelay, strb, exp_resp);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 8'h00;
      seen_mem[i]  = 8'h00;
    end

    // Reset held for two cycles; every output must read zero.
    ARESETn = 1'b0;
    repeat (2) begin
      @(negedge ACLK);
      chk("rst_ctrl", {AWREADY, WREADY, BVALID, BRESP, mem_we}, 6'd0);
      chk("rst_mem", {mem_addr, mem_wdata}, 16'd0);
    end
    tick();
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("rel_ready_early", {AWREADY, WREADY}, 2'b00);
    @(negedge ACLK);
    chk("rel_ready", {AWREADY, WREADY}, 2'b11);

    run_txn(8'h03, 8'hA5, 0, 0, 0, 0, 1'b1);
    run_txn(8'h07, 8'h5A, 1, 3, 0, 0, 1'b1);
    run_txn(8'h09, 8'h3C, 0, 0, 4, 0, 1'b1);
    run_txn(8'h10, 8'hFF, 0, 0, 0, 0, 1'b1);
    run_txn(8'h0F, 8'h81, 2, 2, 0, 6, 1'b1);
`ifdef AXI_WSTRB_EN
    run_txn(8'h04, 8'h11, 0, 0, 0, 6, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [7:0] ra;
      logic [7:0] rd;
      logic       rs;
      ra = 8'($urandom_range(0, 19));
      rd = 8'($urandom);
      rs = 1'b1;
`ifdef AXI_WSTRB_EN
      rs = ($urandom_range(0, 7) != 0);
`endif
      run_txn(ra, rd, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rs);
    end

    // Reset in the middle of WRITE: mem_we drops at once and nothing commits.
    @(negedge ACLK);
    AWADDR  = 8'h05;
    WDATA   = 8'h77;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    mem_busy = 1'b0;
    tick();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    chk("abort_pre_we", mem_we, 1'b1);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("abort_we", mem_we, 1'b0);
    chk("abort_bvalid", BVALID, 1'b0);
    repeat (2) tick();
    ARESETn = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("abort_ready", {AWREADY, WREADY}, 2'b11);
    chk("abort_bvalid_after", BVALID, 1'b0);
    chk("abort_n_commit", commit_q.size(), 0);

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("mem_word_%0d", i), seen_mem[i], model_mem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
